// File: rtl/serial_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits,
// 3-sample majority voting, parity/framing error and break flags.
module serial_rx_cfg #(
    parameter int BAUDRATE        = 115200,
    parameter int CLOCK_FREQUENCY = 48000000,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);
    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUDRATE;
    localparam int MID          = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_LO  = CW'(MID - 1);
    localparam logic [CW-1:0] C_MID = CW'(MID);
    localparam logic [CW-1:0] C_HI  = CW'(MID + 1);
    localparam logic [CW-1:0] C_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam bit            ODD = (PARITY == 1);

    generate
        if (CLKS_PER_BIT < 8) begin : g_bad_rate
            $error("serial_rx_cfg: CLKS_PER_BIT must be at least 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
            $error("serial_rx_cfg: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("serial_rx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("serial_rx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY_BIT, STOP, DONE, BRK_WAIT
    } state_t;

    state_t                state;
    logic                  rx_meta, rxs;
    logic [1:0]            sync_fill;
    logic                  armed;
    logic [CW-1:0]         cnt;
    logic [3:0]            bit_idx;
    logic                  stop_idx;
    logic                  vote_a, vote_b;
    logic [DATA_BITS-1:0]  shreg;
    logic                  par_acc, par_err, stop_err, all_zero;
    logic                  maj, at_hi, cnt_end, last_stop;

    assign maj       = (vote_a & vote_b) | (vote_a & rxs) | (vote_b & rxs);
    assign at_hi     = (cnt == C_HI);
    assign cnt_end   = (cnt == C_END);
    assign last_stop = (STOP_BITS == 1) || stop_idx;
    assign o_Busy    = (state != IDLE);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta      <= 1'b1;
            rxs          <= 1'b1;
            sync_fill    <= '0;
            armed        <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            vote_a       <= 1'b0;
            vote_b       <= 1'b0;
            shreg        <= '0;
            par_acc      <= 1'b0;
            par_err      <= 1'b0;
            stop_err     <= 1'b0;
            all_zero     <= 1'b1;
            o_Rx_DV      <= 1'b0;
            o_Rx_Data    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
        end else begin
            rx_meta   <= i_Rx_Serial;
            rxs       <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            // The synchronizer's reset value is not evidence of an idle line; wait
            // until the real line has propagated through both stages.
            if (sync_fill[1] && rxs) armed <= 1'b1;
            o_Rx_DV <= 1'b0;

            if (state == START || state == DATA || state == PARITY_BIT || state == STOP) begin
                cnt <= cnt_end ? '0 : cnt + 1'b1;
                if (cnt == C_LO)  vote_a <= rxs;
                if (cnt == C_MID) vote_b <= rxs;
            end

            case (state)
                IDLE: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    par_acc  <= 1'b0;
                    par_err  <= 1'b0;
                    stop_err <= 1'b0;
                    all_zero <= 1'b1;
                    if (armed && !rxs) state <= START;
                end
                START: begin
                    if (at_hi && maj) state <= IDLE;
                    else if (cnt_end) state <= DATA;
                end
                DATA: begin
                    if (at_hi) begin
                        shreg   <= {maj, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ maj;
                        if (maj) all_zero <= 1'b0;
                    end
                    if (cnt_end) begin
                        if (bit_idx == LAST_DATA) state <= (PARITY != 0) ? PARITY_BIT : STOP;
                        else bit_idx <= bit_idx + 4'd1;
                    end
                end
                PARITY_BIT: begin
                    if (at_hi) begin
                        par_err <= ((par_acc ^ maj) != ODD);
                        if (maj) all_zero <= 1'b0;
                    end
                    if (cnt_end) state <= STOP;
                end
                STOP: begin
                    // The final stop bit is decided at mid-bit so a following start
                    // edge is never missed.
                    if (at_hi) begin
                        if (last_stop) begin
                            state        <= DONE;
                            o_Rx_DV      <= 1'b1;
                            o_Rx_Data    <= shreg;
                            o_Parity_Err <= par_err;
                            o_Frame_Err  <= stop_err | !maj;
                            o_Break      <= all_zero & !maj;
                        end else begin
                            stop_err <= stop_err | !maj;
                            if (maj) all_zero <= 1'b0;
                        end
                    end
                    if (cnt_end) stop_idx <= 1'b1;
                end
                DONE:     state <= o_Break ? BRK_WAIT : IDLE;
                BRK_WAIT: if (rxs) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end
endmodule
